request_unit: RTL and testbench
===============================

// Module: request_unit
// PURPOSE
//  Memory-request sequencer sitting directly downstream of the decode/control stage in the single-cycle datapath.
//  Consumes MemRd/MemWr/Halt/datomic from decode and the ALU-computed data address.
//  Drives instruction/data read/write enables to the memory controller and advances the PC only when an instruction fully retires.
//  Owns the sticky halt and the LL/SC reservation (link) register.
// PARAMETERS
//  ADDR_W     32  width of data address
//  LINK_LSB   2   lowest address bit used in link compare (word granularity)
// PORTS
//  clk          in   1       system clock, rising edge
//  n_rst        in   1       asynchronous active-low reset
//  ihit         in   1       instruction memory ready (instruction valid this cycle)
//  dhit         in   1       data memory ready (current data access complete)
//  MemRd        in   1       decoded load (LW/LL)
//  MemWr        in   1       decoded store (SW/SC)
//  datomic      in   1       decoded LL or SC
//  Halt         in   1       decoded HALT
//  daddr        in   ADDR_W  data address from ALU, stable while instruction held
//  iREN         out  1       instruction read enable
//  dREN         out  1       data read enable
//  dWEN         out  1       data write enable
//  pc_en        out  1       one-cycle PC advance strobe (instruction retires)
//  halt         out  1       sticky halt to datapath/testbench
//  sc_success   out  1       value SC writes to Rt (1 = store performed)
// BEHAVIOUR
//  - One clock; reset asynchronous active-low; state bits, dREN, dWEN, halt, sc_success, link_valid all reset to 0, state=RU_FETCH.
//  - FSM states: RU_FETCH, RU_DATA, RU_HALT. iREN = (state==RU_FETCH), combinational; dREN/dWEN registered.
//  - RU_FETCH, !ihit: hold, pc_en=0.
//  - RU_FETCH, ihit & Halt: -> RU_HALT next edge; pc_en=0; halt=1 from next cycle, sticky until reset.
//  - RU_FETCH, ihit & !MemRd & !MemWr: pc_en=1 this cycle (combinational), stay RU_FETCH; 1-cycle retire.
//  - RU_FETCH, ihit & MemRd: -> RU_DATA, dREN=1 next cycle. ihit & MemWr: -> RU_DATA, dWEN=1 next cycle.
//  - SC with failed reservation: no dWEN; pc_en=1 same cycle; sc_success<=0; stay RU_FETCH.
//  - RU_DATA: iREN=0; ihit ignored. dREN/dWEN held until dhit; on dhit: pc_en=1 that cycle, dREN/dWEN<=0, -> RU_FETCH.
//  - Minimum load/store latency: ihit cycle + 1 data cycle; no upper bound, stall indefinitely until dhit.
//  - dREN and dWEN never both 1. RU_HALT: all enables 0, pc_en=0, absorbs ihit/dhit.
//  - Simultaneous ihit & dhit in RU_DATA: dhit wins, ihit discarded (iREN was 0).
//  - Reset mid-access (RU_DATA): enables drop immediately (async); the access is abandoned, not replayed.
// CONFIGURATION
//  - Macro LLSC_EN defined: link register active.
//    LL on dhit sets link_valid=1, link_addr=daddr[ADDR_W-1:LINK_LSB].
//    SC succeeds iff link_valid & addr match: dWEN issued, sc_success<=1 on dhit.
//    Any SC clears link_valid at retire. A non-atomic SW whose address matches clears link_valid on its dhit.
//    An LL to a new address overwrites the link.
//  - LLSC_EN undefined: datomic ignored; LL behaves as LW, SC as SW; sc_success<=1 on every SC dhit; no link storage synthesised.
// STRUCTURE
//  - cpu_types_pkg gains: typedef enum logic [1:0] {RU_FETCH, RU_DATA, RU_HALT} ru_state_t; reuse word_t for addresses.
//  - Sub-module link_register (link_valid/link_addr storage, match compare, set/clear inputs) instantiated only under `ifdef LLSC_EN.
//  - The top level holds the FSM and enable registers.
// TESTING
//  - Reset low mid-run -> iREN=1, dREN=dWEN=halt=pc_en=sc_success=0 immediately; state RU_FETCH after release.
//  - ADD, ihit=1 -> pc_en=1 same cycle, dREN/dWEN stay 0.
//  - LW, ihit=1, dhit after 3 stall cycles -> dREN=1 for 4 cycles, iREN=0 throughout, single pc_en pulse on dhit cycle.
//  - HALT, ihit=1 -> halt=1 next cycle and held 20 cycles with ihit/dhit toggling; pc_en never asserts.
//  - LLSC_EN: LL 0x100, then SC 0x100 -> dWEN asserted, sc_success=1. A second SC 0x100 -> no dWEN, sc_success=0.
//  - LLSC_EN: LL 0x200, SW 0x200, SC 0x200 -> SC fails (sc_success=0). Without LLSC_EN the same sequence -> SC writes, sc_success=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and request-unit sequencer states.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        RU_FETCH = 2'd0,
        RU_DATA  = 2'd1,
        RU_HALT  = 2'd2
    } ru_state_t;

endpackage

// File: rtl/link_register.sv
// LL/SC reservation: holds one word tag and reports a live match against the current address.
// Set takes priority over clear, so an LL retiring in the same cycle as a clear still links.
module link_register #(
    parameter int TAG_W = 30
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_set,
    input  logic             i_clr,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_match
);

    logic             r_link_valid;
    logic [TAG_W-1:0] r_link_addr;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
        end else if (i_set) begin
            r_link_valid <= 1'b1;
            r_link_addr  <= i_tag;
        end else if (i_clr) begin
            r_link_valid <= 1'b0;
        end
    end

    assign o_match = r_link_valid && (r_link_addr == i_tag);

endmodule

// File: rtl/request_unit.sv
// Memory-request sequencer: 1-cycle retire for ALU ops, ihit + >=1 data cycle for loads/stores, stalls until dhit.
// LL/SC reservation tracking is built only when LLSC_EN is defined; otherwise SC always stores.
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W   = WORD_W,
    parameter int LINK_LSB = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              MemRd,
    input  logic              MemWr,
    input  logic              datomic,
    input  logic              Halt,
    input  logic [ADDR_W-1:0] daddr,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              pc_en,
    output logic              halt,
    output logic              sc_success
);

    ru_state_t r_state;
    ru_state_t w_state_nxt;

    logic r_dren;
    logic r_dwen;
    logic r_sc;
    logic r_halt;
    logic r_sc_success;

    logic w_start;
    logic w_mem_go;
    logic w_data_done;
    logic w_sc_fail;
    logic w_unused_lsb;

    assign w_start     = (r_state == RU_FETCH) && ihit && !Halt;
    assign w_data_done = (r_state == RU_DATA) && dhit;
    assign w_mem_go    = w_start && (MemRd || MemWr) && !w_sc_fail;
    assign w_unused_lsb = ^daddr[LINK_LSB-1:0];

`ifdef LLSC_EN
    logic r_ll;
    logic w_link_match;
    logic w_link_set;
    logic w_link_clr;

    // A failed SC retires from FETCH without a data phase, so it must be caught before dWEN is raised.
    assign w_sc_fail  = MemWr && datomic && !w_link_match;
    assign w_link_set = w_data_done && r_ll;
    assign w_link_clr = (w_start && w_sc_fail) ||
                        (w_data_done && r_dwen && (r_sc || w_link_match));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ll <= 1'b0;
        end else if (w_mem_go) begin
            r_ll <= MemRd && datomic;
        end
    end

    link_register #(
        .TAG_W (ADDR_W - LINK_LSB)
    ) u_link_register (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_set   (w_link_set),
        .i_clr   (w_link_clr),
        .i_tag   (daddr[ADDR_W-1:LINK_LSB]),
        .o_match (w_link_match)
    );
`else
    logic w_unused_tag;

    assign w_sc_fail    = 1'b0;
    assign w_unused_tag = ^daddr[ADDR_W-1:LINK_LSB];
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= RU_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RU_FETCH: begin
                if (ihit && Halt) begin
                    w_state_nxt = RU_HALT;
                end else if (w_mem_go) begin
                    w_state_nxt = RU_DATA;
                end
            end
            RU_DATA: begin
                if (dhit) begin
                    w_state_nxt = RU_FETCH;
                end
            end
            RU_HALT: w_state_nxt = RU_HALT;
            default: w_state_nxt = RU_FETCH;
        endcase
    end

    always_comb begin
        iREN  = (r_state == RU_FETCH);
        pc_en = 1'b0;
        if (w_start && !w_mem_go) begin
            pc_en = 1'b1;
        end else if (w_data_done) begin
            pc_en = 1'b1;
        end
    end

    // MemRd wins if decode ever flags both, keeping dREN/dWEN mutually exclusive.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_dren       <= 1'b0;
            r_dwen       <= 1'b0;
            r_sc         <= 1'b0;
            r_halt       <= 1'b0;
            r_sc_success <= 1'b0;
        end else begin
            if (w_mem_go) begin
                r_dren <= MemRd;
                r_dwen <= MemWr && !MemRd;
                r_sc   <= MemWr && !MemRd && datomic;
            end else if (w_data_done) begin
                r_dren <= 1'b0;
                r_dwen <= 1'b0;
                if (r_sc) begin
                    r_sc_success <= 1'b1;
                end
            end
            if (w_start && w_sc_fail) begin
                r_sc_success <= 1'b0;
            end
            if ((r_state == RU_FETCH) && ihit && Halt) begin
                r_halt <= 1'b1;
            end
        end
    end

    assign dREN       = r_dren;
    assign dWEN       = r_dwen;
    assign halt       = r_halt;
    assign sc_success = r_sc_success;

endmodule

// File: tb/tb_request_unit.sv
// Bench for request_unit: directed and random instruction streams against an instruction-level reference model.
module tb_request_unit;
    import cpu_types_pkg::*;

    localparam int K_ADD = 0;
    localparam int K_LW  = 1;
    localparam int K_SW  = 2;
    localparam int K_LL  = 3;
    localparam int K_SC  = 4;

    logic  clk = 1'b0;
    logic  n_rst = 1'b0;
    logic  ihit = 1'b0;
    logic  dhit = 1'b0;
    logic  MemRd = 1'b0;
    logic  MemWr = 1'b0;
    logic  datomic = 1'b0;
    logic  Halt = 1'b0;
    word_t daddr = '0;
    logic  iREN, dREN, dWEN, pc_en, halt, sc_success;

    int total = 0;
    int bad = 0;

    // Reference model state: architectural reservation and the visible sticky flags.
    logic          m_link_valid = 1'b0;
    logic [29:0]   m_link_tag = '0;
    logic          m_sc = 1'b0;
    logic          m_halt = 1'b0;

    word_t addr_tbl [4];

    request_unit dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .ihit       (ihit),
        .dhit       (dhit),
        .MemRd      (MemRd),
        .MemWr      (MemWr),
        .datomic    (datomic),
        .Halt       (Halt),
        .daddr      (daddr),
        .iREN       (iREN),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .pc_en      (pc_en),
        .halt       (halt),
        .sc_success (sc_success)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic e_iren, input logic e_dren, input logic e_dwen, input logic e_pc);
        chk("iREN", iREN, e_iren);
        chk("dREN", dREN, e_dren);
        chk("dWEN", dWEN, e_dwen);
        chk("pc_en", pc_en, e_pc);
        chk("halt", halt, m_halt);
        chk("sc_success", sc_success, m_sc);
    endtask

    // Inputs are set at a falling edge; outputs are checked 1ns later, then we wait for the next falling edge.
    task automatic step(input logic e_iren, input logic e_dren, input logic e_dwen, input logic e_pc);
        #1;
        check_outputs(e_iren, e_dren, e_dwen, e_pc);
        @(negedge clk);
    endtask

    task automatic idle();
        ihit = 1'b0; dhit = 1'b0;
        MemRd = 1'b0; MemWr = 1'b0; datomic = 1'b0; Halt = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_instr(input int kind, input word_t addr, input int stall);
        logic rd, wr, at, mem, sc_ok, match;
        rd = (kind == K_LW) || (kind == K_LL);
        wr = (kind == K_SW) || (kind == K_SC);
        at = (kind == K_LL) || (kind == K_SC);
        match = m_link_valid && (m_link_tag == addr[31:2]);
`ifdef LLSC_EN
        sc_ok = match;
`else
        sc_ok = 1'b1;
`endif
        mem = (rd || wr) && !((kind == K_SC) && !sc_ok);

        ihit = 1'b1; dhit = 1'b0; Halt = 1'b0;
        MemRd = rd; MemWr = wr; datomic = at; daddr = addr;
        step(1'b1, 1'b0, 1'b0, !mem);

        if (mem) begin
            for (int i = 0; i <= stall; i++) begin
                ihit = 1'($urandom_range(0, 1));
                dhit = (i == stall);
                step(1'b0, rd, wr, i == stall);
            end
        end

        if (kind == K_SC) begin
            m_sc = sc_ok;
        end
`ifdef LLSC_EN
        if (kind == K_LL) begin
            m_link_valid = 1'b1;
            m_link_tag   = addr[31:2];
        end else if (kind == K_SC || (kind == K_SW && match)) begin
            m_link_valid = 1'b0;
        end
`endif
        ihit = 1'b0; dhit = 1'b0;
        MemRd = 1'b0; MemWr = 1'b0; datomic = 1'b0;
    endtask

    initial begin
        addr_tbl[0] = 32'h100;
        addr_tbl[1] = 32'h103;
        addr_tbl[2] = 32'h104;
        addr_tbl[3] = 32'h200;

        // Reset state while held in reset.
        #3;
        check_outputs(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;

        idle();
        do_instr(K_ADD, 32'h0, 0);
        do_instr(K_LW, 32'h40, 3);
        do_instr(K_SW, 32'h44, 0);
        idle();

        do_instr(K_LL, 32'h100, 1);
        do_instr(K_SC, 32'h100, 0);
        do_instr(K_SC, 32'h100, 2);

        do_instr(K_LL, 32'h200, 0);
        do_instr(K_SW, 32'h200, 1);
        do_instr(K_SC, 32'h200, 0);

        // Reset asserted in the middle of a stalled load.
        ihit = 1'b1; MemRd = 1'b1; daddr = 32'h300;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        ihit = 1'b0; dhit = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        n_rst = 1'b0;
        m_sc = 1'b0;
        m_link_valid = 1'b0;
        #1;
        check_outputs(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        MemRd = 1'b0;
        idle();
        do_instr(K_ADD, 32'h0, 0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end
            do_instr(int'($urandom_range(0, 4)), addr_tbl[$urandom_range(0, 3)],
                     int'($urandom_range(0, 3)));
        end

        // Halt: sticky and deaf to further handshakes.
        ihit = 1'b1; Halt = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        m_halt = 1'b1;
        for (int n = 0; n < 20; n++) begin
            ihit  = 1'($urandom_range(0, 1));
            dhit  = 1'($urandom_range(0, 1));
            MemRd = 1'($urandom_range(0, 1));
            MemWr = !MemRd;
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
